// File: rtl/sram_resp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sram_resp_pkg
//  Description : Shared types and constants for the SRAM bus responder.
//  Revision    : 1.0  initial release
// ============================================================================
package sram_resp_pkg;

    localparam int WAIT_CNT_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_STROBE  = 3'd2,
        ST_ACK     = 3'd3,
        ST_RECOVER = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/sram_resp_rcache.sv
`default_nettype none
// ============================================================================
//  Module      : sram_resp_rcache
//  Description : One-entry read cache (valid, 19-bit tag, 16-bit word).
//                Only instantiated when SRAM_RESP_READ_CACHE_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
module sram_resp_rcache (
    input  logic        clk,
    input  logic        reset,
    input  logic [18:0] lookup_addr,
    output logic        hit,
    output logic [15:0] hit_data,
    input  logic        fill_en,
    input  logic [18:0] fill_addr,
    input  logic [15:0] fill_data,
    input  logic        inval_en,
    input  logic [18:0] inval_addr
);

    logic        r_valid;
    logic [18:0] r_tag;
    logic [15:0] r_data;

    assign hit      = r_valid && (r_tag == lookup_addr);
    assign hit_data = r_data;

    // Fill wins over invalidate; the two never coincide because a fill
    // happens mid-transaction and an invalidate only at request time.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_valid <= 1'b0;
            r_tag   <= '0;
            r_data  <= '0;
        end else if (fill_en) begin
            r_valid <= 1'b1;
            r_tag   <= fill_addr;
            r_data  <= fill_data;
        end else if (inval_en && (inval_addr == r_tag)) begin
            r_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sram_bus_responder.sv
`default_nettype none
// ============================================================================
//  Module      : sram_bus_responder
//  Description : Bus-to-asynchronous-SRAM responder with programmable strobe
//                width. Optional read cache via SRAM_RESP_READ_CACHE_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module sram_bus_responder
    import sram_resp_pkg::*;
#(
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        bus_access,
    input  logic        bus_wr_en,
    input  logic [18:0] bus_addr,
    input  logic [1:0]  bus_bytesel,
    input  logic [15:0] bus_wdata,
    output logic [15:0] bus_rdata,
    output logic        bus_ack,
    output logic [18:0] sram_addr,
    output logic [15:0] sram_dq_o,
    input  logic [15:0] sram_dq_i,
    output logic        sram_dq_oe,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n,
    output logic        sram_ub_n,
    output logic        sram_lb_n
);

    localparam logic [WAIT_CNT_W-1:0] c_cnt_load = WAIT_CNT_W'(WAIT_STATES - 1);

    state_t                r_state;
    logic [WAIT_CNT_W-1:0] r_cnt;
    logic                  r_wr_en;
    logic [18:0]           r_addr;
    logic [1:0]            r_bytesel;
    logic [15:0]           r_wdata;

    logic                  w_null_wr;
    logic                  w_hit_rd;
    logic [15:0]           w_hit_data;

    // A write with no byte lanes selected runs the full timing but never
    // touches the SRAM.
    assign w_null_wr = r_wr_en && (r_bytesel == 2'b00);

`ifdef SRAM_RESP_READ_CACHE_EN
    logic w_cache_hit;
    logic w_fill;
    logic w_inval;

    assign w_fill   = (r_state == ST_STROBE) && !r_wr_en && (r_cnt == '0);
    assign w_inval  = (r_state == ST_IDLE) && bus_access && bus_wr_en;
    assign w_hit_rd = bus_access && !bus_wr_en && w_cache_hit;

    sram_resp_rcache u_rcache (
        .clk         (clk),
        .reset       (reset),
        .lookup_addr (bus_addr),
        .hit         (w_cache_hit),
        .hit_data    (w_hit_data),
        .fill_en     (w_fill),
        .fill_addr   (r_addr),
        .fill_data   (sram_dq_i),
        .inval_en    (w_inval),
        .inval_addr  (bus_addr)
    );
`else
    assign w_hit_rd   = 1'b0;
    assign w_hit_data = 16'h0000;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_wr_en    <= 1'b0;
            r_addr     <= '0;
            r_bytesel  <= '0;
            r_wdata    <= '0;
            bus_rdata  <= '0;
            bus_ack    <= 1'b0;
            sram_addr  <= '0;
            sram_dq_o  <= '0;
            sram_dq_oe <= 1'b0;
            sram_ce_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
            sram_ub_n  <= 1'b1;
            sram_lb_n  <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    bus_ack <= 1'b0;
                    if (bus_access) begin
                        r_wr_en   <= bus_wr_en;
                        r_addr    <= bus_addr;
                        r_bytesel <= bus_bytesel;
                        r_wdata   <= bus_wdata;
                        if (w_hit_rd) begin
                            bus_rdata <= w_hit_data;
                            r_state   <= ST_ACK;
                        end else begin
                            r_state   <= ST_SETUP;
                        end
                    end
                end

                ST_SETUP: begin
                    sram_addr <= r_addr;
                    r_cnt     <= c_cnt_load;
                    sram_ce_n <= w_null_wr;
                    if (r_wr_en) begin
                        sram_dq_oe <= 1'b1;
                        sram_dq_o  <= r_wdata;
                    end else begin
                        sram_oe_n  <= 1'b0;
                    end
                    r_state <= ST_STROBE;
                end

                ST_STROBE: begin
                    if (r_wr_en) begin
                        sram_we_n <= w_null_wr;
                        sram_ub_n <= ~r_bytesel[1];
                        sram_lb_n <= ~r_bytesel[0];
                    end else begin
                        sram_ub_n <= 1'b0;
                        sram_lb_n <= 1'b0;
                    end
                    if (r_cnt == '0) begin
                        if (!r_wr_en) begin
                            bus_rdata <= sram_dq_i;
                        end
                        r_state <= ST_ACK;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end

                // Write data stays on the bus through ACK to cover SRAM hold time.
                ST_ACK: begin
                    bus_ack   <= 1'b1;
                    sram_ce_n <= 1'b1;
                    sram_oe_n <= 1'b1;
                    sram_we_n <= 1'b1;
                    sram_ub_n <= 1'b1;
                    sram_lb_n <= 1'b1;
                    r_state   <= ST_RECOVER;
                end

                ST_RECOVER: begin
                    bus_ack    <= 1'b0;
                    sram_dq_oe <= 1'b0;
                    sram_ce_n  <= 1'b1;
                    sram_oe_n  <= 1'b1;
                    sram_we_n  <= 1'b1;
                    sram_ub_n  <= 1'b1;
                    sram_lb_n  <= 1'b1;
                    r_state    <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_bus_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sram_bus_responder
//  Description : Directed self-checking bench for sram_bus_responder
//                (WAIT_STATES = 2; cache scenario when SRAM_RESP_READ_CACHE_EN).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sram_bus_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        bus_access;
    logic        bus_wr_en;
    logic [18:0] bus_addr;
    logic [1:0]  bus_bytesel;
    logic [15:0] bus_wdata;
    logic [15:0] bus_rdata;
    logic        bus_ack;
    logic [18:0] sram_addr;
    logic [15:0] sram_dq_o;
    logic [15:0] sram_dq_i;
    logic        sram_dq_oe;
    logic        sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

    logic [15:0] sram_word;
    int          n_checks = 0;
    int          n_errors = 0;

    int          n_ack, ack_idx0, ack_idx1, n_oe, oe_first, n_ce, n_we, n_ub, n_lb;
    logic [15:0] rec_dqoe;
    logic [18:0] at_addr;
    logic [15:0] at_dqo;

    always #5 clk = ~clk;

    // SRAM model: drives the stored word only while chip and output enable are low.
    assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? sram_word : 16'h0000;

    sram_bus_responder #(.WAIT_STATES(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus_access (bus_access),
        .bus_wr_en  (bus_wr_en),
        .bus_addr   (bus_addr),
        .bus_bytesel(bus_bytesel),
        .bus_wdata  (bus_wdata),
        .bus_rdata  (bus_rdata),
        .bus_ack    (bus_ack),
        .sram_addr  (sram_addr),
        .sram_dq_o  (sram_dq_o),
        .sram_dq_i  (sram_dq_i),
        .sram_dq_oe (sram_dq_oe),
        .sram_ce_n  (sram_ce_n),
        .sram_oe_n  (sram_oe_n),
        .sram_we_n  (sram_we_n),
        .sram_ub_n  (sram_ub_n),
        .sram_lb_n  (sram_lb_n)
    );

    // Records n cycles after the sampling edge; index i is the cycle starting
    // i edges after it. Drops bus_access (and optionally scrambles inputs) at drop_at.
    task automatic capture(input int n, input int drop_at, input bit scramble);
        n_ack = 0; ack_idx0 = -1; ack_idx1 = -1; n_oe = 0; oe_first = -1;
        n_ce = 0; n_we = 0; n_ub = 0; n_lb = 0; rec_dqoe = '0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus_ack === 1'b1) begin
                if (ack_idx0 < 0) ack_idx0 = i; else if (ack_idx1 < 0) ack_idx1 = i;
                n_ack++;
            end
            if (sram_oe_n === 1'b0) begin
                if (oe_first < 0) oe_first = i;
                n_oe++;
            end
            if (sram_ce_n === 1'b0) n_ce++;
            if (sram_we_n === 1'b0) n_we++;
            if (sram_ub_n === 1'b0) n_ub++;
            if (sram_lb_n === 1'b0) n_lb++;
            if (i < 16) rec_dqoe[i] = sram_dq_oe;
            if (i == 1) begin
                at_addr = sram_addr;
                at_dqo  = sram_dq_o;
            end
            if (i == drop_at) begin
                bus_access = 1'b0;
                if (scramble) begin
                    bus_addr    = ~bus_addr;
                    bus_wdata   = ~bus_wdata;
                    bus_bytesel = ~bus_bytesel;
                    bus_wr_en   = ~bus_wr_en;
                end
            end
        end
    endtask

    task automatic start(input logic wr, input logic [18:0] a, input logic [1:0] bs,
                         input logic [15:0] wd);
        bus_wr_en   = wr;
        bus_addr    = a;
        bus_bytesel = bs;
        bus_wdata   = wd;
        bus_access  = 1'b1;
    endtask

    task automatic test_reset;
        reset = 1'b0; bus_access = 1'b0; bus_wr_en = 1'b0;
        bus_addr = '0; bus_bytesel = '0; bus_wdata = '0; sram_word = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (bus_ack !== 1'b0) begin n_errors++; $display("FAIL rst_ack: got %b expected 0", bus_ack); end
        n_checks++; if (bus_rdata !== 16'h0000) begin n_errors++; $display("FAIL rst_rdata: got %h expected 0000", bus_rdata); end
        n_checks++; if (sram_addr !== 19'h0) begin n_errors++; $display("FAIL rst_addr: got %h expected 0", sram_addr); end
        n_checks++; if (sram_dq_o !== 16'h0) begin n_errors++; $display("FAIL rst_dq_o: got %h expected 0", sram_dq_o); end
        n_checks++; if (sram_dq_oe !== 1'b0) begin n_errors++; $display("FAIL rst_dq_oe: got %b expected 0", sram_dq_oe); end
        n_checks++;
        if ({sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n} !== 5'b11111) begin
            n_errors++;
            $display("FAIL rst_strobes: got %b expected 11111",
                     {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n});
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_read;
        sram_word = 16'hBEEF;
        start(1'b0, 19'h00010, 2'b01, 16'h0000);
        capture(12, 0, 1'b1);
        n_checks++; if (n_oe != 3) begin n_errors++; $display("FAIL read_oe_cycles: got %0d expected 3", n_oe); end
        n_checks++; if (oe_first != 1) begin n_errors++; $display("FAIL read_oe_first: got %0d expected 1", oe_first); end
        n_checks++; if (ack_idx0 != 4) begin n_errors++; $display("FAIL read_ack_cycle: got %0d expected 4", ack_idx0); end
        n_checks++; if (n_ack != 1) begin n_errors++; $display("FAIL read_ack_count: got %0d expected 1", n_ack); end
        n_checks++; if (bus_rdata !== 16'hBEEF) begin n_errors++; $display("FAIL read_rdata: got %h expected beef", bus_rdata); end
        n_checks++; if (at_addr !== 19'h00010) begin n_errors++; $display("FAIL read_addr: got %h expected 00010", at_addr); end
        n_checks++; if (n_we != 0 || rec_dqoe != 16'h0) begin n_errors++; $display("FAIL read_no_drive: got we=%0d dqoe=%h expected 0 0", n_we, rec_dqoe); end
        n_checks++; if (n_ub != 2 || n_lb != 2) begin n_errors++; $display("FAIL read_lanes: got ub=%0d lb=%0d expected 2 2", n_ub, n_lb); end
    endtask

    task automatic test_write;
        sram_word = 16'h0000;
        start(1'b1, 19'h7FFFF, 2'b10, 16'h1234);
        capture(12, 0, 1'b1);
        n_checks++; if (n_we != 2) begin n_errors++; $display("FAIL write_we_cycles: got %0d expected 2", n_we); end
        n_checks++; if (n_ub != 2 || n_lb != 0) begin n_errors++; $display("FAIL write_lanes: got ub=%0d lb=%0d expected 2 0", n_ub, n_lb); end
        n_checks++; if (at_dqo !== 16'h1234) begin n_errors++; $display("FAIL write_dq_o: got %h expected 1234", at_dqo); end
        n_checks++; if (at_addr !== 19'h7FFFF) begin n_errors++; $display("FAIL write_addr: got %h expected 7ffff", at_addr); end
        n_checks++; if (rec_dqoe[11:0] !== 12'h01E) begin n_errors++; $display("FAIL write_dq_oe_profile: got %h expected 01e", rec_dqoe[11:0]); end
        n_checks++; if (ack_idx0 != 4 || n_ack != 1) begin n_errors++; $display("FAIL write_ack: got idx=%0d cnt=%0d expected 4 1", ack_idx0, n_ack); end
        n_checks++; if (n_oe != 0) begin n_errors++; $display("FAIL write_oe: got %0d expected 0", n_oe); end
        n_checks++; if (bus_rdata !== 16'hBEEF) begin n_errors++; $display("FAIL write_rdata_hold: got %h expected beef", bus_rdata); end
    endtask

    task automatic test_back_to_back;
        sram_word = 16'h5A5A;
        start(1'b0, 19'h00123, 2'b11, 16'h0000);
        capture(18, 6, 1'b0);
        n_checks++; if (n_ack != 2) begin n_errors++; $display("FAIL b2b_ack_count: got %0d expected 2", n_ack); end
        n_checks++; if (ack_idx0 != 4 || ack_idx1 != 10) begin n_errors++; $display("FAIL b2b_ack_cycles: got %0d,%0d expected 4,10", ack_idx0, ack_idx1); end
        n_checks++; if (n_oe != 6) begin n_errors++; $display("FAIL b2b_oe_cycles: got %0d expected 6", n_oe); end
        n_checks++; if (bus_rdata !== 16'h5A5A) begin n_errors++; $display("FAIL b2b_rdata: got %h expected 5a5a", bus_rdata); end
    endtask

    task automatic test_null_write;
        start(1'b1, 19'h00055, 2'b00, 16'hFFFF);
        capture(12, 0, 1'b0);
        n_checks++;
        if (n_ce + n_oe + n_we + n_ub + n_lb != 0) begin
            n_errors++;
            $display("FAIL null_wr_strobes: got ce=%0d oe=%0d we=%0d ub=%0d lb=%0d expected all 0",
                     n_ce, n_oe, n_we, n_ub, n_lb);
        end
        n_checks++; if (ack_idx0 != 4 || n_ack != 1) begin n_errors++; $display("FAIL null_wr_ack: got idx=%0d cnt=%0d expected 4 1", ack_idx0, n_ack); end
    endtask

    task automatic test_reset_mid;
        int acks;
        start(1'b1, 19'h00100, 2'b11, 16'hCAFE);
        @(posedge clk); @(negedge clk);
        bus_access = 1'b0;
        repeat (2) begin @(posedge clk); @(negedge clk); end
        n_checks++; if (sram_we_n !== 1'b0) begin n_errors++; $display("FAIL mid_we_before: got %b expected 0", sram_we_n); end
        reset = 1'b0;
        @(posedge clk); @(negedge clk);
        n_checks++; if (sram_we_n !== 1'b1 || sram_ce_n !== 1'b1) begin n_errors++; $display("FAIL mid_strobes: got we=%b ce=%b expected 1 1", sram_we_n, sram_ce_n); end
        n_checks++; if (sram_dq_oe !== 1'b0) begin n_errors++; $display("FAIL mid_dq_oe: got %b expected 0", sram_dq_oe); end
        reset = 1'b1;
        acks = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); @(negedge clk);
            if (bus_ack === 1'b1) acks++;
        end
        n_checks++; if (acks != 0) begin n_errors++; $display("FAIL mid_no_ack: got %0d expected 0", acks); end
    endtask

`ifdef SRAM_RESP_READ_CACHE_EN
    task automatic test_cache;
        sram_word = 16'hA5A5;
        start(1'b0, 19'h00020, 2'b11, 16'h0000);
        capture(12, 0, 1'b0);
        n_checks++; if (ack_idx0 != 4 || bus_rdata !== 16'hA5A5) begin n_errors++; $display("FAIL cache_fill: got idx=%0d data=%h expected 4 a5a5", ack_idx0, bus_rdata); end
        sram_word = 16'h1111;
        start(1'b0, 19'h00020, 2'b11, 16'h0000);
        capture(8, 0, 1'b0);
        n_checks++; if (ack_idx0 != 1 || n_ack != 1) begin n_errors++; $display("FAIL cache_hit_ack: got idx=%0d cnt=%0d expected 1 1", ack_idx0, n_ack); end
        n_checks++; if (n_ce + n_oe != 0) begin n_errors++; $display("FAIL cache_hit_strobes: got ce=%0d oe=%0d expected 0 0", n_ce, n_oe); end
        n_checks++; if (bus_rdata !== 16'hA5A5) begin n_errors++; $display("FAIL cache_hit_data: got %h expected a5a5", bus_rdata); end
        start(1'b1, 19'h00020, 2'b11, 16'h7777);
        capture(12, 0, 1'b0);
        sram_word = 16'h3C3C;
        start(1'b0, 19'h00020, 2'b11, 16'h0000);
        capture(12, 0, 1'b0);
        n_checks++; if (ack_idx0 != 4 || n_oe != 3) begin n_errors++; $display("FAIL cache_inval: got idx=%0d oe=%0d expected 4 3", ack_idx0, n_oe); end
        n_checks++; if (bus_rdata !== 16'h3C3C) begin n_errors++; $display("FAIL cache_inval_data: got %h expected 3c3c", bus_rdata); end
    endtask
`endif

    initial begin
        test_reset();
        test_read();
        test_write();
        test_back_to_back();
        test_null_write();
        test_reset_mid();
`ifdef SRAM_RESP_READ_CACHE_EN
        test_cache();
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sram_bus_responder.md
SRAM_BUS_RESPONDER -- requirements
Module: sram_bus_responder

Interface
REQ-001 Parameter WAIT_STATES, default 2, SRAM strobe width in clk cycles; legal range 1..15.
REQ-002 clk  input  1  sole clock; all logic on rising edge.
REQ-003 reset  input  1  one clock, reset synchronous, active-low (0 = reset), sampled on rising clk.
REQ-004 bus_access  input  1  initiator request; sampled only in IDLE.
REQ-005 bus_wr_en  input  1  1 = write, 0 = read.
REQ-006 bus_addr  input  19  word address, bits [19:1].
REQ-007 bus_bytesel  input  2  byte lanes; bit0 = [7:0], bit1 = [15:8].
REQ-008 bus_wdata  input  16  write data.
REQ-009 bus_rdata  output  16  read data, registered.
REQ-010 bus_ack  output  1  one-cycle completion pulse, registered.
REQ-011 sram_addr  output  19  SRAM word address.
REQ-012 sram_dq_o / sram_dq_i / sram_dq_oe  output/input/output  16/16/1  split bidirectional data; pad tristate external.
REQ-013 sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n  output  1 each  active-low SRAM strobes, all registered.

Function
REQ-014 States: IDLE, SETUP, STROBE, ACK, RECOVER.
REQ-015 IDLE with bus_access=1: latch addr, wdata, bytesel, wr_en; go SETUP; otherwise stay.
REQ-016 SETUP: ce_n=0, address driven; write: dq_oe=1, dq_o=latched wdata; read: oe_n=0; counter loads WAIT_STATES-1; go STROBE.
REQ-017 STROBE: write: we_n=0, ub_n/lb_n = ~bytesel; read: ub_n=lb_n=0 (full word fetched); counter decrements; at count 0 read captures sram_dq_i into bus_rdata; go ACK.
REQ-018 ACK: bus_ack=1 for exactly one cycle; we_n, oe_n, ce_n high; dq_oe held 1 on writes (data hold); go RECOVER.
REQ-019 RECOVER: dq_oe=0, all strobes high, bus_access ignored (turnaround); go IDLE.
REQ-020 Latency: bus_ack asserts in the cycle starting 2+WAIT_STATES edges after the edge that sampled bus_access; RECOVER adds one further cycle before the next sample.
REQ-021 bus_bytesel=2'b00 write: no SRAM strobe asserted in any state; ack timing unchanged.
REQ-022 bus_access or bus_* inputs changing after IDLE: ignored; the transaction completes on latched values.
REQ-023 bus_rdata holds its last captured value through writes and idle; unselected lanes are passed unmodified.

Reset
REQ-024 On reset: state IDLE, bus_ack=0, bus_rdata=0, sram_addr=0, dq_o=0, dq_oe=0, all sram_*_n=1, counter=0.
REQ-025 Reset mid-transaction: strobes high and dq_oe=0 from the next edge; no ack issued for the aborted transaction.

Configuration
REQ-026 Macro SRAM_RESP_READ_CACHE_EN: when defined, a one-entry read cache (valid, 19-bit tag, 16-bit word) is included.
REQ-027 With the macro: IDLE read with valid and tag==bus_addr goes directly to ACK, bus_rdata=cached word, no SRAM strobes; every completed SRAM read fills the entry; a write to tag address invalidates; reset clears valid.
REQ-028 Without the macro: every read follows REQ-016..019; no cache storage is synthesized.

Structure
REQ-029 Package sram_resp_pkg holds the state enum and WAIT_CNT_W=4 constant.
REQ-030 Cache held in sub-module sram_resp_rcache, instantiated only under SRAM_RESP_READ_CACHE_EN.

Verification
REQ-031 WAIT_STATES=2, read addr 0x00010, SRAM returns 0xBEEF -> oe_n low 3 cycles, bus_ack in 4th cycle after request, bus_rdata=0xBEEF.
REQ-032 Write addr 0x7FFFF, wdata 0x1234, bytesel 2'b10 -> we_n low 2 cycles, ub_n=0, lb_n=1, dq_o=0x1234, dq_oe drops in RECOVER.
REQ-033 bus_access held high continuously for two reads -> two acks separated by RECOVER+IDLE, exactly one ack per transaction.
REQ-034 Reset low in STROBE of a write -> we_n=1, dq_oe=0 next edge; bus_ack never asserted.
REQ-035 Macro defined: read 0x00020 (0xA5A5), reread 0x00020 -> second ack 1 cycle after request, no strobes; write 0x00020 then read -> full SRAM cycle.
REQ-036 bytesel=2'b00 write -> no strobe ever low, bus_ack at nominal latency.
